alu_op_sequencer: RTL and testbench

//   Queues ALU operation commands and drives the combinational 16-bit ALU port set (EN, select,
//   src1, src2), one operation at a time. Captures the ALU answer and returns it on a valid/ready

---
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Handshake and bus bundle between the command source, the ALU op
// sequencer and the combinational ALU.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SEL_W-1:0]  cmd_sel;
  logic [DATA_W-1:0] cmd_src1;
  logic [DATA_W-1:0] cmd_src2;
  logic              alu_en;
  logic [SEL_W-1:0]  alu_select;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [DATA_W-1:0] alu_ans;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [SEL_W-1:0]  res_sel;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_sel, cmd_src1, cmd_src2, alu_ans, res_ready,
    output cmd_ready, alu_en, alu_select, alu_src1, alu_src2,
           res_valid, res_data, res_sel, fifo_count, busy
  );

  // Command source / result consumer / ALU side
  modport master (
    output cmd_valid, cmd_sel, cmd_src1, cmd_src2, alu_ans, res_ready,
    input  cmd_ready, alu_en, alu_select, alu_src1, alu_src2,
           res_valid, res_data, res_sel, fifo_count, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: queues commands in a small FIFO, issues them one at a
// time to a combinational ALU and returns each answer on a valid/ready
// result channel, in command order.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// ISSUE | alu_en high, operands on the ALU, answer captured at closing edge
// HOLD  | result presented, waiting for res_ready
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_op_sequencer_if.slave  bus_io
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [SEL_W-1:0]    mem_sel_q  [DEPTH];
  logic [DATA_W-1:0]   mem_src1_q [DEPTH];
  logic [DATA_W-1:0]   mem_src2_q [DEPTH];
  logic [SEL_W-1:0]    alu_select_q;
  logic [DATA_W-1:0]   alu_src1_q, alu_src2_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic [SEL_W-1:0]    res_sel_q;
  logic                cmd_ready;
  logic                push, pop;

  // No pass-through when full: readiness looks only at the stored count.
  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = bus_io.cmd_valid & cmd_ready;

  // Next-state and pop decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD: begin
        if (bus_io.res_ready) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, written on accepted commands only
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_sel_q[wr_ptr_q]  <= bus_io.cmd_sel;
      mem_src1_q[wr_ptr_q] <= bus_io.cmd_src1;
      mem_src2_q[wr_ptr_q] <= bus_io.cmd_src2;
    end
  end

  // Control state, pointers, ALU operand and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      alu_select_q <= '0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_sel_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        alu_select_q <= mem_sel_q[rd_ptr_q];
        alu_src1_q   <= mem_src1_q[rd_ptr_q];
        alu_src2_q   <= mem_src2_q[rd_ptr_q];
      end
      if (state_q == S_ISSUE) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus_io.alu_ans;
        res_sel_q   <= alu_select_q;
      end else if (state_q == S_HOLD && bus_io.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus_io.cmd_ready  = cmd_ready;
  assign bus_io.alu_en     = (state_q == S_ISSUE);
  assign bus_io.alu_select = alu_select_q;
  assign bus_io.alu_src1   = alu_src1_q;
  assign bus_io.alu_src2   = alu_src2_q;
  assign bus_io.res_valid  = res_valid_q;
  assign bus_io.res_data   = res_data_q;
  assign bus_io.res_sel    = res_sel_q;
  assign bus_io.fifo_count = count_q;
  assign bus_io.busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. The ALU is a stub:
// ans = src1 + src2 + select (16-bit wrap).
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [18:0] got_q[$];
  int          en_cnt = 0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_ans = bus.alu_src1 + bus.alu_src2 + {13'b0, bus.alu_select};

  // Record result handshakes and ALU enable cycles as seen at each edge
  always @(posedge clk) begin
    if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1)
      got_q.push_back({bus.res_sel, bus.res_data});
    if (bus.alu_en === 1'b1) en_cnt++;
  end

  // Present a command and hold it until accepted (or budget expires)
  task automatic push_cmd(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b,
                          input int budget, output bit ok);
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_src1  = a;
    bus.cmd_src2  = b;
    for (int c = 0; c < budget; c++) begin
      if (bus.cmd_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL push_accept: accepted=%0b required=1", ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_src1 = '0; bus.cmd_src2 = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got=%0b exp=1", bus.cmd_ready); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_fifo_count: got=%0d exp=0", bus.fifo_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got=%0b exp=0", bus.busy); end
    n_cmp++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL rst_alu_en: got=%0b exp=0", bus.alu_en); end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got=%0b exp=0", bus.res_valid); end
    n_cmp++;
    if ({bus.alu_select, bus.alu_src1, bus.alu_src2, bus.res_data, bus.res_sel} !== 54'd0) begin
      n_fail++;
      $display("FAIL rst_datapath: sel=%h s1=%h s2=%h rd=%h rs=%h exp all 0",
               bus.alu_select, bus.alu_src1, bus.alu_src2, bus.res_data, bus.res_sel);
    end
  endtask

  // Single command: push edge N, alu_en visible after edge N+1, result after edge N+2
  task automatic test_single();
    int en0;
    en0 = en_cnt;
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_sel = 3'b001; bus.cmd_src1 = 16'hF0F0; bus.cmd_src2 = 16'h0F0F;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n_cmp++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got=%0d exp=1", bus.fifo_count); end
    n_cmp++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL single_en_early: got=%0b exp=0", bus.alu_en); end
    @(posedge clk); #1;
    n_cmp++; if (bus.alu_en !== 1'b1) begin n_fail++; $display("FAIL single_en: got=%0b exp=1", bus.alu_en); end
    n_cmp++;
    if (bus.alu_select !== 3'b001 || bus.alu_src1 !== 16'hF0F0 || bus.alu_src2 !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL single_operands: got=%h/%h/%h exp=1/f0f0/0f0f", bus.alu_select, bus.alu_src1, bus.alu_src2);
    end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_pop: got=%0d exp=0", bus.fifo_count); end
    @(posedge clk); #1;
    n_cmp++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL single_en_off: got=%0b exp=0", bus.alu_en); end
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_res_valid: got=%0b exp=1", bus.res_valid); end
    n_cmp++; if (bus.res_data !== 16'h0000) begin n_fail++; $display("FAIL single_res_data: got=%h exp=0000", bus.res_data); end
    n_cmp++; if (bus.res_sel !== 3'b001) begin n_fail++; $display("FAIL single_res_sel: got=%h exp=1", bus.res_sel); end
    @(posedge clk); #1;
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_res_drop: got=%0b exp=0", bus.res_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got=%0b exp=0", bus.busy); end
    n_cmp++; if (en_cnt - en0 !== 1) begin n_fail++; $display("FAIL single_en_cycles: got=%0d exp=1", en_cnt - en0); end
    n_cmp++;
    if (got_q.size() !== 1 || got_q[0] !== {3'b001, 16'h0000}) begin
      n_fail++;
      $display("FAIL single_result: size=%0d exp size=1 value 1/0000", got_q.size());
    end
    bus.res_ready = 1'b0;
  endtask

  // Stalled consumer: 5 accepted, 6th waits for space, all 6 return in order
  task automatic test_back_to_back();
    logic [2:0]  sel [6];
    logic [15:0] a   [6];
    logic [15:0] b   [6];
    logic [18:0] exp;
    bit ok;
    int base;
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      sel[i] = 3'(i + 1);
      a[i]   = 16'(16'h1111 * (i + 1));
      b[i]   = 16'hF0FF;
    end
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(sel[i], a[i], b[i], 2, ok);
    n_cmp++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got=%0d exp=4", bus.fifo_count); end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got=%0b exp=0", bus.cmd_ready); end
    fork
      push_cmd(sel[5], a[5], b[5], 30, ok);
      begin
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_stall_count: got=%0d exp=4", bus.fifo_count); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got=%0b exp=0", bus.cmd_ready); end
        bus.res_ready = 1'b1;
      end
    join
    base = 0;
    for (int c = 0; c < 40 && got_q.size() < 6; c++) begin @(posedge clk); #1; end
    n_cmp++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL b2b_count: got=%0d results exp=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      exp = {sel[i], 16'(a[i] + b[i] + {13'b0, sel[i]})};
      n_cmp++;
      if (got_q[i] !== exp) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got=%h exp=%h", i, got_q[i], exp);
      end
    end
    bus.res_ready = 1'b0;
  endtask

  // Full throughput: results 2,3,4,5 with res_valid every second cycle
  task automatic test_throughput();
    logic [9:0]  seen;
    logic [9:0]  exp_pat;
    logic [15:0] exp_data [4];
    bit ok;
    got_q.delete();
    exp_pat = 10'b0101010100;
    exp_data[0] = 16'd2; exp_data[1] = 16'd3; exp_data[2] = 16'd4; exp_data[3] = 16'd5;
    seen = '0;
    bus.res_ready = 1'b1;
    fork
      for (int i = 0; i < 4; i++) push_cmd(3'(i), 16'd1, 16'd1, 2, ok);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        seen[i] = bus.res_valid;
      end
    join
    n_cmp++; if (seen !== exp_pat) begin n_fail++; $display("FAIL tput_valid_pattern: got=%b exp=%b", seen, exp_pat); end
    n_cmp++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL tput_count: got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== {3'(i), exp_data[i]}) begin
        n_fail++;
        $display("FAIL tput_result[%0d]: got=%h exp=%h", i, got_q[i], {3'(i), exp_data[i]});
      end
    end
    bus.res_ready = 1'b0;
  endtask

  // Result held stable across a 5-cycle stall, one handshake gives one result
  task automatic test_hold();
    bit ok;
    int n0;
    got_q.delete();
    bus.res_ready = 1'b0;
    push_cmd(3'd5, 16'h1234, 16'h4321, 2, ok);
    for (int c = 0; c < 10 && bus.res_valid !== 1'b1; c++) begin @(posedge clk); #1; end
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL hold_wait: res_valid=%0b exp=1 within budget", bus.res_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h555A || bus.res_sel !== 3'd5) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%0b d=%h s=%0d exp v=1 d=555a s=5",
                 i, bus.res_valid, bus.res_data, bus.res_sel);
      end
    end
    n0 = got_q.size();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() - n0 !== 1) begin n_fail++; $display("FAIL hold_one_result: got=%0d exp=1", got_q.size() - n0); end
    n_cmp++; if (got_q.size() > 0 && got_q[got_q.size()-1] !== {3'd5, 16'h555A}) begin
      n_fail++; $display("FAIL hold_value: got=%h exp=%h", got_q[got_q.size()-1], {3'd5, 16'h555A}); end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL hold_after: res_valid=%0b exp=0", bus.res_valid); end
  endtask

  // Reset while ISSUE with two commands still queued
  task automatic test_reset_mid();
    bit ok;
    int n0, e0;
    bus.res_ready = 1'b0;
    push_cmd(3'd2, 16'd10, 16'd20, 2, ok);
    push_cmd(3'd3, 16'd11, 16'd21, 2, ok);
    push_cmd(3'd4, 16'd12, 16'd22, 2, ok);
    push_cmd(3'd6, 16'd13, 16'd23, 2, ok);
    n_cmp++; if (bus.res_valid !== 1'b1 || bus.fifo_count !== 3'd3) begin
      n_fail++; $display("FAIL rmid_setup: v=%0b cnt=%0d exp v=1 cnt=3", bus.res_valid, bus.fifo_count); end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    n_cmp++; if (bus.alu_en !== 1'b1 || bus.fifo_count !== 3'd2) begin
      n_fail++; $display("FAIL rmid_issue: en=%0b cnt=%0d exp en=1 cnt=2", bus.alu_en, bus.fifo_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL rmid_en: got=%0b exp=0", bus.alu_en); end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_res_valid: got=%0b exp=0", bus.res_valid); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got=%0d exp=0", bus.fifo_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got=%0b exp=0", bus.busy); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got=%0b exp=1", bus.cmd_ready); end
    rst = 1'b0;
    bus.res_ready = 1'b1;
    n0 = got_q.size();
    e0 = en_cnt;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() !== n0) begin n_fail++; $display("FAIL rmid_no_result: got=%0d new results exp=0", got_q.size() - n0); end
    n_cmp++; if (en_cnt !== e0) begin n_fail++; $display("FAIL rmid_no_issue: got=%0d enable cycles exp=0", en_cnt - e0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: busy=%0b exp=0", bus.busy); end
    bus.res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_throughput();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
